// File: rtl/seq_shift_add_mult.sv
// Sequential radix-2 shift-add multiplier.
// Consumes one multiplier bit per cycle, LSB first, for WIDTH cycles.
// In signed mode the multiplier MSB carries negative weight, so that
// partial product is subtracted, which makes the result exact for
// two's-complement operands.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for start; operands captured on acceptance
// RUN   | iterating, one multiplier bit per cycle (busy=1)
// DONE  | single-cycle done pulse, product freshly loaded
module seq_shift_add_mult #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [PW-1:0]    mcand_sh;
    logic [WIDTH-1:0] mplier_sh;
    logic             smode;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    acc_next;
    logic [CW-1:0]    cnt;
    logic             last;

    // The iteration currently being processed is the multiplier MSB.
    assign last = (cnt == CW'(WIDTH - 1));

    // Partial-product accumulate; the signed MSB iteration subtracts.
    always_comb begin
        acc_next = acc;
        if (mplier_sh[0]) begin
            if (smode && last) begin
                acc_next = acc - mcand_sh;
            end else begin
                acc_next = acc + mcand_sh;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: operand capture, shifting, accumulation and product load.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_sh  <= '0;
            mplier_sh <= '0;
            smode     <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            product   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (signed_mode) begin
                            mcand_sh <= {{WIDTH{multiplicand[WIDTH-1]}}, multiplicand};
                        end else begin
                            mcand_sh <= {{WIDTH{1'b0}}, multiplicand};
                        end
                        mplier_sh <= multiplier;
                        smode     <= signed_mode;
                        acc       <= '0;
                        cnt       <= '0;
                    end
                end
                RUN: begin
                    acc       <= acc_next;
                    mcand_sh  <= mcand_sh << 1;
                    mplier_sh <= mplier_sh >> 1;
                    cnt       <= cnt + CW'(1);
                    if (last) begin
                        product <= acc_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
